// File: rtl/kp_line_feeder.sv
// Line feeder: pops greyscale pixels from the input FIFO and delivers
// one full line per kernel-control request, tracking line/frame position.
module kp_line_feeder #(
  parameter int LINE_LENGTH = 480,
  parameter int NUM_LINES   = 480,
  parameter int REQ_GUARD   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_req,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd,
  input  logic [7:0] i_fifo_data,
  output logic       o_busy,
  output logic       o_line_done,
  output logic       o_frame_done,
  output logic [8:0] o_line_cnt
);

  localparam int GW = $clog2(REQ_GUARD + 1);

  localparam logic [9:0]    LL    = 10'(LINE_LENGTH);
  localparam logic [9:0]    LL_M1 = 10'(LINE_LENGTH - 1);
  localparam logic [8:0]    NL_M1 = 9'(NUM_LINES - 1);
  localparam logic [GW-1:0] G_M1  = GW'(REQ_GUARD - 1);

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    GUARD
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [9:0]    rd_cnt;
  logic [9:0]    wr_cnt;
  logic [GW-1:0] guard_cnt;
  logic [8:0]    line_cnt;
  logic          valid_q;
  logic          rd;
  logic          line_done;
  logic          start;

  assign line_done = valid_q && (state == LINE) && (wr_cnt == LL_M1);
  assign start     = (state == IDLE) && (state_nx == LINE);

  always_comb begin
    rd       = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_req && i_en && !i_fifo_empty) begin
          rd       = 1'b1;
          state_nx = LINE;
        end
      end
      LINE: begin
        rd = !i_fifo_empty && (rd_cnt < LL);
        if (line_done) state_nx = GUARD;
      end
      GUARD: begin
        if (guard_cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset must silence the pop and valid in the very cycle it is raised
  assign o_fifo_rd    = rd && !i_rst;
  assign o_valid      = valid_q && !i_rst;
  assign o_data       = o_valid ? i_fifo_data : 8'd0;
  assign o_busy       = (state != IDLE) && !i_rst;
  assign o_line_done  = line_done && !i_rst;
  assign o_frame_done = o_line_done && (line_cnt == NL_M1);
  assign o_line_cnt   = line_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      guard_cnt <= '0;
      line_cnt  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_q <= o_fifo_rd;
      // The line's first pop is issued from IDLE, so it is counted here
      if (start) rd_cnt <= 10'd1;
      else if (o_fifo_rd) rd_cnt <= rd_cnt + 10'd1;
      if (start) wr_cnt <= '0;
      else if (valid_q && state == LINE) wr_cnt <= wr_cnt + 10'd1;
      if (state == LINE && state_nx == GUARD) guard_cnt <= G_M1;
      else if (state == GUARD && guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
      if (line_done) line_cnt <= (line_cnt == NL_M1) ? 9'd0 : line_cnt + 9'd1;
    end
  end

endmodule

// File: tb/tb_kp_line_feeder.sv
// Directed bench for kp_line_feeder with a ramp-data FIFO model,
// reduced to 16-pixel lines and 5-line frames.
module tb_kp_line_feeder;

  localparam int LL = 16;
  localparam int NL = 5;
  localparam int RG = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req;
  logic [7:0] data;
  logic       valid;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;
  logic       busy;
  logic       line_done;
  logic       frame_done;
  logic [8:0] line_cnt;

  int   tests = 0;
  int   fails = 0;

  int   added = 0;
  int   popped = 0;
  int   underflow = 0;
  logic force_empty = 1'b0;

  int       px_cnt = 0;
  int       line_px = 0;
  int       done_cnt = 0;
  int       frame_cnt = 0;
  int       bad_done = 0;
  int       bad_frame = 0;
  int       data_err = 0;
  int       gap = 0;
  int       last_gap = 0;
  logic [7:0] mon_exp = 8'd0;

  kp_line_feeder #(
    .LINE_LENGTH(LL),
    .NUM_LINES  (NL),
    .REQ_GUARD  (RG)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req       (req),
    .o_data      (data),
    .o_valid     (valid),
    .i_fifo_empty(fifo_empty),
    .o_fifo_rd   (fifo_rd),
    .i_fifo_data (fifo_data),
    .o_busy      (busy),
    .o_line_done (line_done),
    .o_frame_done(frame_done),
    .o_line_cnt  (line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (added == popped) || force_empty;

  // FIFO model: ramp data, returned one cycle after the pop
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (added == popped) underflow <= underflow + 1;
      fifo_data <= popped[7:0];
      popped    <= popped + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      line_px = 0;
      mon_exp = popped[7:0];
    end else if (valid) begin
      if (data !== mon_exp) data_err++;
      mon_exp = mon_exp + 8'd1;
      px_cnt++;
      last_gap = gap;
      gap = 0;
      if (line_done) begin
        if (line_px != LL - 1) bad_done++;
        done_cnt++;
        line_px = 0;
      end else begin
        line_px++;
      end
      if (frame_done) begin
        frame_cnt++;
        if (!line_done || done_cnt != NL) bad_frame++;
      end
    end else begin
      gap++;
      if (line_done || frame_done) bad_done++;
      if (data !== 8'd0) data_err++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_px(input string tag, input int n);
    int b = 0;
    while (px_cnt < n && b < 2000) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk(tag, int'(px_cnt >= n), 1);
  endtask

  task automatic wait_busy(input string tag);
    int b = 0;
    while (!busy && b < 200) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk(tag, int'(busy), 1);
  endtask

  int pre;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 1'b0;
    cyc(2);
    chk("rst_valid", int'(valid), 0);
    chk("rst_rd", int'(fifo_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_line_cnt", int'(line_cnt), 0);
    chk("rst_data", int'(data), 0);
    rst = 1'b0;
    cyc(2);

    // three back-to-back lines, extra line of data in the FIFO
    added = 4 * LL;
    req   = 1'b1;
    wait_px("t1_wait", 3 * LL);
    chk("t1_done_cnt", done_cnt, 3);
    cyc(2);
    req = 1'b0;
    chk("t1_line_cnt", int'(line_cnt), 3);
    cyc(20);
    chk("t2_no_4th", px_cnt, 3 * LL);
    chk("t2_idle", int'(busy), 0);
    req = 1'b1;
    wait_busy("t2_start");
    req = 1'b0;
    wait_px("t2_wait", 4 * LL);
    cyc(20);
    chk("t2_px", px_cnt, 4 * LL);
    chk("t2_line_cnt", int'(line_cnt), 4);

    // FIFO runs dry for 10 cycles mid-line; this is the last line of the frame
    added = added + LL;
    req   = 1'b1;
    wait_px("t3_mid", 4 * LL + 8);
    force_empty = 1'b1;
    cyc(10);
    force_empty = 1'b0;
    wait_px("t3_resume", 4 * LL + 9);
    chk("t3_gap", last_gap, 10);
    wait_px("t3_wait", 5 * LL);
    req = 1'b0;
    cyc(20);
    chk("t3_px", px_cnt, 5 * LL);
    chk("t4_frame_cnt", frame_cnt, 1);
    chk("t4_line_wrap", int'(line_cnt), 0);
    chk("t4_done_cnt", done_cnt, 5);

    // async reset with a pop outstanding
    added = added + LL;
    req   = 1'b1;
    wait_px("t5_mid", 5 * LL + 4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_valid", int'(valid), 0);
    chk("t5_rd", int'(fifo_rd), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_data", int'(data), 0);
    pre = px_cnt;
    cyc(2);
    chk("t5_no_valid", px_cnt, pre);
    chk("t5_popped", popped, 5 * LL + 5);
    added = added + 5;
    rst = 1'b0;
    wait_px("t5_wait", pre + LL);
    cyc(20);
    chk("t5_px", px_cnt, pre + LL);
    chk("t5_line_cnt", int'(line_cnt), 1);

    // enable dropped mid-line
    pre   = px_cnt;
    added = added + 2 * LL;
    wait_busy("t6_start");
    wait_px("t6_mid", pre + 10);
    en = 1'b0;
    wait_px("t6_wait", pre + LL);
    cyc(20);
    chk("t6_px", px_cnt, pre + LL);
    chk("t6_parked", int'(busy), 0);
    chk("t6_no_rd", int'(fifo_rd), 0);
    en = 1'b1;
    #1;
    chk("t6_rd_now", int'(fifo_rd), 1);
    cyc(1);
    chk("t6_busy", int'(busy), 1);
    wait_px("t6_wait2", pre + 2 * LL);
    req = 1'b0;
    cyc(10);
    chk("t6_line_cnt", int'(line_cnt), 3);
    chk("t6_done_cnt", done_cnt, 8);

    chk("data_order", data_err, 0);
    chk("line_done_pos", bad_done, 0);
    chk("frame_pos", bad_frame, 0);
    chk("frame_total", frame_cnt, 1);
    chk("underflow", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
